// File: rtl/wam_ctl_pkg.sv
// Shared types and constants for the Whac-A-Mole controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: round states, mole sub-phases, LFSR seed/taps, BCD helpers.
package wam_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  typedef enum logic {
    PH_GAP = 1'b0,
    PH_UP  = 1'b1
  } phase_t;

  // x^8+x^6+x^5+x^4+1 as a Fibonacci shift-left: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Two-digit BCD decrement, {tens,ones}; 00 is never decremented in use.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int sec);
    return 8'(((sec / 10) << 4) | (sec % 10));
  endfunction

endpackage

// File: rtl/wam_ctl_if.sv
// Game-side signal bundle between the player/score logic and wam_ctl.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// Signals: start (level), hit[7:0], holes[7:0] one-hot, playing, over,
//          time_left BCD {tens,ones}, scr_clr pulse.
interface wam_ctl_if;
  logic       start;
  logic [7:0] hit;
  logic [7:0] holes;
  logic       playing;
  logic       over;
  logic [7:0] time_left;
  logic       scr_clr;

  // master: the environment driving start/hit; slave: the controller.
  modport master (
    output start, hit,
    input  holes, playing, over, time_left, scr_clr
  );

  modport slave (
    input  start, hit,
    output holes, playing, over, time_left, scr_clr
  );
endinterface

// File: rtl/wam_lfsr.sv
// Free-running 8-bit maximal-length LFSR used for hole selection.
// Latency: new value every clk_19 cycle; q is registered.
// Backpressure: none; advances unconditionally, never reaches 0.
// Ports: clk_19 clock, clr_n async active-low reset to seed, q[7:0] state.
module wam_lfsr
  import wam_ctl_pkg::*;
(
  input  logic       clk_19,
  input  logic       clr_n,
  output logic [7:0] q
);

  always_ff @(posedge clk_19 or negedge clr_n) begin
    if (!clr_n) q <= LFSR_SEED;
    else        q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/wam_ctl.sv
// Whac-A-Mole round sequencer: IDLE->PLAY->OVER, mole popping, BCD countdown.
// Latency: all outputs registered; start edge to playing/scr_clr is one cycle.
// Backpressure: none; hits outside the lit hole or during GAP are dropped.
// Ports: clk_19, clr_n (async active-low), bus (wam_ctl_if.slave).
module wam_ctl
  import wam_ctl_pkg::*;
#(
  parameter int SEC_TICKS = 95,
  parameter int GAME_SEC  = 60,
  parameter int MOLE_UP   = 64,
  parameter int UP_MIN    = 16,
  parameter int UP_STEP   = 8,
  parameter int GAP       = 16
) (
  input  logic      clk_19,
  input  logic      clr_n,
  wam_ctl_if.slave  bus
);

  localparam int         SW        = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam logic [7:0] TIME_INIT = to_bcd(GAME_SEC);

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic            start_q;
  logic [7:0]      time_q, time_d;
  logic [SW-1:0]   sec_q, sec_d;
  logic [7:0]      gap_q, gap_d;
  logic [7:0]      life_q, life_d;
  logic [7:0]      up_q, up_d;
  logic [7:0]      holes_q, holes_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      whack_q, whack_d;
  logic            scr_clr_q, scr_clr_d;
  logic            playing_q, over_q;

  logic [7:0]      lfsr;
  logic            unused_lfsr;
  logic            start_edge;
  logic            sec_wrap;
  logic [2:0]      cand;
  logic [2:0]      pick;

  wam_lfsr u_lfsr (
    .clk_19 (clk_19),
    .clr_n  (clr_n),
    .q      (lfsr)
  );

  // Only the low three bits choose a hole.
  assign unused_lfsr = ^lfsr[7:3];

  assign start_edge = bus.start & ~start_q;
  assign sec_wrap   = (sec_q == SW'(SEC_TICKS - 1));
  assign cand       = lfsr[2:0];
  // Never light the same hole twice in a row.
  assign pick       = (cand == idx_q) ? cand + 3'd1 : cand;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    time_d    = time_q;
    sec_d     = sec_q;
    gap_d     = gap_q;
    life_d    = life_q;
    up_d      = up_q;
    holes_d   = holes_q;
    idx_d     = idx_q;
    whack_d   = whack_q;
    scr_clr_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        holes_d = 8'h00;
        if (start_edge) begin
          state_d   = ST_PLAY;
          scr_clr_d = 1'b1;
          time_d    = TIME_INIT;
          sec_d     = '0;
          phase_d   = PH_GAP;
          gap_d     = 8'd0;
          up_d      = 8'(MOLE_UP);
          whack_d   = 3'd0;
        end
      end

      ST_PLAY: begin
        sec_d = sec_wrap ? '0 : sec_q + SW'(1);
        if (sec_wrap) time_d = bcd_dec(time_q);

        if (sec_wrap && time_q == 8'h01) begin
          // Round end beats any mole activity this cycle, including a whack.
          state_d = ST_OVER;
          holes_d = 8'h00;
          phase_d = PH_GAP;
          gap_d   = 8'd0;
        end else if (phase_q == PH_GAP) begin
          if (gap_q == 8'(GAP - 1)) begin
            idx_d   = pick;
            holes_d = 8'h01 << pick;
            life_d  = up_q;
            phase_d = PH_UP;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end else begin
          // A hit on the final lit cycle still counts as a whack.
          if (bus.hit[idx_q]) begin
            holes_d = 8'h00;
            phase_d = PH_GAP;
            gap_d   = 8'd0;
            whack_d = whack_q + 3'd1;
            if (whack_q == 3'd7) begin
              if ({1'b0, up_q} >= 9'(UP_MIN + UP_STEP)) up_d = up_q - 8'(UP_STEP);
              else                                      up_d = 8'(UP_MIN);
            end
          end else if (life_q <= 8'd1) begin
            holes_d = 8'h00;
            phase_d = PH_GAP;
            gap_d   = 8'd0;
          end else begin
            life_d = life_q - 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        holes_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk_19 or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_GAP;
      start_q   <= 1'b0;
      time_q    <= TIME_INIT;
      sec_q     <= '0;
      gap_q     <= 8'd0;
      life_q    <= 8'd0;
      up_q      <= 8'(MOLE_UP);
      holes_q   <= 8'h00;
      idx_q     <= 3'd0;
      whack_q   <= 3'd0;
      scr_clr_q <= 1'b0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      start_q   <= bus.start;
      time_q    <= time_d;
      sec_q     <= sec_d;
      gap_q     <= gap_d;
      life_q    <= life_d;
      up_q      <= up_d;
      holes_q   <= holes_d;
      idx_q     <= idx_d;
      whack_q   <= whack_d;
      scr_clr_q <= scr_clr_d;
      playing_q <= (state_d == ST_PLAY);
      over_q    <= (state_d == ST_OVER);
    end
  end

  assign bus.holes     = holes_q;
  assign bus.playing   = playing_q;
  assign bus.over      = over_q;
  assign bus.time_left = time_q;
  assign bus.scr_clr   = scr_clr_q;

endmodule

// File: tb/tb_wam_ctl.sv
// Directed bench for wam_ctl: a 3-second round instance and a 99-second
// instance for level-up. Inputs driven and outputs sampled on negedge.
module tb_wam_ctl;

  logic clk_19;
  logic clr_n;
  int   n_vec = 0;
  int   n_err = 0;

  wam_ctl_if sif ();
  wam_ctl_if lif ();

  wam_ctl #(
    .SEC_TICKS(4), .GAME_SEC(3), .MOLE_UP(8), .UP_MIN(4), .UP_STEP(2), .GAP(2)
  ) u_dut (
    .clk_19 (clk_19),
    .clr_n  (clr_n),
    .bus    (sif)
  );

  wam_ctl #(
    .SEC_TICKS(4), .GAME_SEC(99), .MOLE_UP(8), .UP_MIN(4), .UP_STEP(2), .GAP(2)
  ) u_long (
    .clk_19 (clk_19),
    .clr_n  (clr_n),
    .bus    (lif)
  );

  initial clk_19 = 1'b0;
  always #5 clk_19 = ~clk_19;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_19);
  endtask

  // Waits for the next mole on the long instance, optionally hits it on lit
  // cycle whack_at (0 = never), and returns gap length, lifetime and pattern.
  task automatic run_mole(input int whack_at, output int gap, output int life,
                          output logic [7:0] pat);
    gap  = 0;
    life = 0;
    while (lif.holes == 8'h00 && gap < 40) begin
      step();
      gap++;
    end
    pat = lif.holes;
    while (lif.holes == pat && pat != 8'h00 && life < 40) begin
      life++;
      lif.hit = (life == whack_at) ? pat : 8'h00;
      step();
    end
    lif.hit = 8'h00;
    chk("mole_clear", lif.holes, 8'h00);
  endtask

  initial begin
    logic [7:0] pat, pat2, prev;
    int gap, life, wat, exp_life;

    clr_n     = 1'b0;
    sif.start = 1'b0;
    sif.hit   = 8'h00;
    lif.start = 1'b0;
    lif.hit   = 8'h00;

    // Reset state
    repeat (3) step();
    chk("rst_holes",   sif.holes, 8'h00);
    chk("rst_playing", sif.playing, 1'b0);
    chk("rst_over",    sif.over, 1'b0);
    chk("rst_scr_clr", sif.scr_clr, 1'b0);
    chk("rst_time",    sif.time_left, 8'h03);
    chk("rst_time_l",  lif.time_left, 8'h99);
    clr_n = 1'b1;
    repeat (2) step();
    chk("idle_playing", sif.playing, 1'b0);

    // Round 1: held start, no hits
    sif.start = 1'b1;
    step();
    chk("r1_scr_clr", sif.scr_clr, 1'b1);
    chk("r1_playing", sif.playing, 1'b1);
    chk("r1_time0",   sif.time_left, 8'h03);
    chk("r1_gap0",    sif.holes, 8'h00);
    step();
    chk("r1_scr_clr_1cyc", sif.scr_clr, 1'b0);
    chk("r1_gap1", sif.holes, 8'h00);
    step();
    pat = sif.holes;
    chk("r1_onehot", $countones(pat), 1);
    for (int c = 3; c <= 11; c++) begin
      step();
      chk("r1_holes", sif.holes, (c <= 9) ? pat : 8'h00);
      if (c == 4) chk("r1_time4", sif.time_left, 8'h02);
      if (c == 8) chk("r1_time8", sif.time_left, 8'h01);
    end
    step();
    chk("r1_over",     sif.over, 1'b1);
    chk("r1_play_end", sif.playing, 1'b0);
    chk("r1_time_end", sif.time_left, 8'h00);
    chk("r1_holes_end", sif.holes, 8'h00);
    repeat (4) step();
    chk("r1_held_over",    sif.over, 1'b1);
    chk("r1_held_playing", sif.playing, 1'b0);
    chk("r1_held_scr",     sif.scr_clr, 1'b0);

    // Round 2: restart from OVER, wrong-bit hit, whack, hit on final wrap
    sif.start = 1'b0;
    step();
    sif.start = 1'b1;
    step();
    chk("r2_scr_clr", sif.scr_clr, 1'b1);
    chk("r2_time0",   sif.time_left, 8'h03);
    chk("r2_playing", sif.playing, 1'b1);
    chk("r2_over0",   sif.over, 1'b0);
    step();
    step();
    pat = sif.holes;
    chk("r2_onehot", $countones(pat), 1);
    sif.hit = ~pat;
    step();
    chk("r2_other_bits", sif.holes, pat);
    sif.hit = 8'h00;
    step();
    chk("r2_up3", sif.holes, pat);
    sif.hit = pat;
    step();
    sif.hit = 8'h00;
    chk("r2_whack_clr", sif.holes, 8'h00);
    step();
    chk("r2_gap2", sif.holes, 8'h00);
    step();
    pat2 = sif.holes;
    chk("r2_onehot2", $countones(pat2), 1);
    chk("r2_no_repeat", (pat2 != pat) ? 1 : 0, 1);
    for (int c = 8; c <= 11; c++) begin
      step();
      chk("r2_holes2", sif.holes, pat2);
    end
    sif.hit = pat2;
    step();
    sif.hit = 8'h00;
    chk("r2_over",      sif.over, 1'b1);
    chk("r2_holes_end", sif.holes, 8'h00);
    chk("r2_time_end",  sif.time_left, 8'h00);
    chk("r2_play_end",  sif.playing, 1'b0);

    // Round 3: asynchronous reset while a mole is lit
    sif.start = 1'b0;
    step();
    sif.start = 1'b1;
    repeat (3) step();
    chk("r3_lit", (sif.holes != 8'h00) ? 1 : 0, 1);
    clr_n     = 1'b0;
    sif.start = 1'b0;
    #1;
    chk("r3_arst_holes",   sif.holes, 8'h00);
    chk("r3_arst_playing", sif.playing, 1'b0);
    chk("r3_arst_time",    sif.time_left, 8'h03);
    chk("r3_arst_over",    sif.over, 1'b0);
    repeat (2) step();
    clr_n = 1'b1;
    step();
    chk("r3_idle", sif.playing, 1'b0);

    // Long round: level-up, expiry-cycle whack, no repeats, GAP length
    lif.start = 1'b1;
    step();
    chk("lg_scr_clr", lif.scr_clr, 1'b1);
    chk("lg_time0",   lif.time_left, 8'h99);
    prev = 8'h00;
    for (int m = 1; m <= 27; m++) begin
      if (m == 8)                          begin wat = 8; exp_life = 8; end
      else if (m == 9)                     begin wat = 0; exp_life = 6; end
      else if (m == 18 || m == 27)         begin wat = 0; exp_life = 4; end
      else                                 begin wat = 1; exp_life = 1; end
      run_mole(wat, gap, life, pat);
      chk("lg_gap", gap, 2);
      chk("lg_life", life, exp_life);
      chk("lg_onehot", $countones(pat), 1);
      chk("lg_no_repeat", (pat != prev) ? 1 : 0, 1);
      prev = pat;
    end
    chk("lg_still_playing", lif.playing, 1'b1);
    chk("lg_not_over",      lif.over, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
